// File: rtl/delta_ctrl_pkg.sv
// rtl/delta_ctrl_pkg.sv - state codes, select-word layout and microprogram table for delta_ctrl
package delta_ctrl_pkg;

    localparam int STEPS  = 8;
    localparam int STEP_W = $clog2(STEPS);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam int SEL2_W    = 2;
    localparam int SEL_IN5_W = 3;
    localparam int GATE_ID_W = 2;

    localparam logic [SEL_IN5_W-1:0] SEL_IN5_LABEL = 3'b000;
    localparam logic [SEL_IN5_W-1:0] SEL_IN5_ZERO  = 3'b111;

    typedef struct packed {
        logic [SEL2_W-1:0]    sel_in1;
        logic [SEL2_W-1:0]    sel_in2;
        logic                 sel_in3;
        logic [SEL2_W-1:0]    sel_in4;
        logic [SEL_IN5_W-1:0] sel_in5;
        logic [SEL2_W-1:0]    sel_x1_1;
        logic                 sel_x1_2;
        logic [SEL2_W-1:0]    sel_x2_2;
        logic                 sel_as_1;
        logic [SEL2_W-1:0]    sel_as_2;
        logic                 sel_addsub;
        logic [SEL2_W-1:0]    sel_temp;
        logic                 dgate_valid;
        logic [GATE_ID_W-1:0] dgate_id;
        logic                 dstate_valid;
    } ucode_t;

    // Idle word parks the datapath: temp register holds, in4/in5/x1_1 on their unused inputs.
    localparam ucode_t SAFE_WORD = '{2'd0, 2'd0, 1'b0, 2'd3, 3'd7, 2'd3, 1'b0, 2'd0,
                                     1'b0, 2'd0, 1'b0, 2'd2, 1'b0, 2'd0, 1'b0};

    // Step 0 stores the label select for sel_in5; hidden layers override it to zero.
    localparam ucode_t DELTA_UCODE [STEPS] = '{
        '{2'd1, 2'd0, 1'b0, 2'd0, 3'd0, 2'd0, 1'b0, 2'd0, 1'b1, 2'd0, 1'b1, 2'd0, 1'b0, 2'd0, 1'b0},
        '{2'd2, 2'd1, 1'b1, 2'd1, 3'd1, 2'd1, 1'b0, 2'd1, 1'b0, 2'd1, 1'b0, 2'd1, 1'b0, 2'd0, 1'b0},
        '{2'd3, 2'd2, 1'b0, 2'd2, 3'd2, 2'd2, 1'b1, 2'd2, 1'b0, 2'd2, 1'b1, 2'd2, 1'b0, 2'd0, 1'b0},
        '{2'd0, 2'd3, 1'b1, 2'd3, 3'd3, 2'd3, 1'b1, 2'd3, 1'b1, 2'd3, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1},
        '{2'd1, 2'd0, 1'b0, 2'd0, 3'd4, 2'd0, 1'b0, 2'd0, 1'b1, 2'd0, 1'b0, 2'd1, 1'b1, 2'd0, 1'b0},
        '{2'd1, 2'd1, 1'b0, 2'd1, 3'd4, 2'd1, 1'b1, 2'd1, 1'b0, 2'd1, 1'b1, 2'd1, 1'b1, 2'd1, 1'b0},
        '{2'd2, 2'd2, 1'b1, 2'd2, 3'd5, 2'd2, 1'b1, 2'd2, 1'b1, 2'd2, 1'b0, 2'd1, 1'b1, 2'd2, 1'b0},
        '{2'd3, 2'd3, 1'b1, 2'd2, 3'd6, 2'd2, 1'b0, 2'd3, 1'b0, 2'd3, 1'b1, 2'd2, 1'b1, 2'd3, 1'b0}
    };

endpackage

// File: rtl/delta_ctrl_ucode.sv
// rtl/delta_ctrl_ucode.sv - combinational microprogram lookup (step, out_layer) -> select word
module delta_ctrl_ucode
    import delta_ctrl_pkg::*;
(
    input  logic [STEP_W-1:0] i_step,
    input  logic              i_out_layer,
    output ucode_t            o_word
);

    always_comb begin
        o_word = DELTA_UCODE[i_step];
        if (i_step == '0 && !i_out_layer) begin
            o_word.sel_in5 = SEL_IN5_ZERO;
        end
    end

endmodule

// File: rtl/delta_ctrl.sv
// rtl/delta_ctrl.sv - LSTM delta datapath sequencer; DELTA_CTRL_PERF_EN adds cycle/stall counters
module delta_ctrl
    import delta_ctrl_pkg::*;
#(
    parameter int NEURON     = 4,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic                  i_stall,
    input  logic                  i_out_layer,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic [1:0]            o_sel_in1,
    output logic [1:0]            o_sel_in2,
    output logic                  o_sel_in3,
    output logic [1:0]            o_sel_in4,
    output logic [2:0]            o_sel_in5,
    output logic [1:0]            o_sel_x1_1,
    output logic                  o_sel_x1_2,
    output logic [1:0]            o_sel_x2_2,
    output logic                  o_sel_as_1,
    output logic [1:0]            o_sel_as_2,
    output logic                  o_sel_addsub,
    output logic [1:0]            o_sel_temp,
    output logic                  o_dgate_valid,
    output logic [1:0]            o_dgate_id,
    output logic                  o_dstate_valid
`ifdef DELTA_CTRL_PERF_EN
    ,
    output logic [15:0]           o_cyc_cnt,
    output logic [15:0]           o_stall_cnt
`endif
);

    logic [1:0]            r_state;
    logic [STEP_W-1:0]     r_step;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_out_layer;
    ucode_t                r_word;

    logic                  w_last_step;
    logic                  w_last_addr;
    logic [STEP_W-1:0]     w_lu_step;
    logic                  w_lu_out_layer;
    ucode_t                w_lu_word;

    assign w_last_step = (r_step == STEP_W'(STEPS - 1));
    assign w_last_addr = (r_addr == ADDR_WIDTH'(NEURON - 1));

    // Look up the word for the step about to be entered so selects register alongside step.
    assign w_lu_step      = (r_state == RUN && !w_last_step) ? r_step + 1'b1 : '0;
    assign w_lu_out_layer = (r_state == RUN) ? r_out_layer : i_out_layer;

    delta_ctrl_ucode u_ucode (
        .i_step      (w_lu_step),
        .i_out_layer (w_lu_out_layer),
        .o_word      (w_lu_word)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_step      <= '0;
            r_addr      <= '0;
            r_out_layer <= 1'b0;
            r_word      <= SAFE_WORD;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_state     <= RUN;
                        r_step      <= '0;
                        r_addr      <= '0;
                        r_out_layer <= i_out_layer;
                        r_word      <= w_lu_word;
                    end
                end
                RUN: begin
                    if (i_stall) begin
                        r_word.dgate_valid  <= 1'b0;
                        r_word.dstate_valid <= 1'b0;
                    end else if (w_last_step) begin
                        r_step <= '0;
                        if (w_last_addr) begin
                            r_state <= DONE;
                            r_word  <= SAFE_WORD;
                        end else begin
                            r_addr <= r_addr + 1'b1;
                            r_word <= w_lu_word;
                        end
                    end else begin
                        r_step <= r_step + 1'b1;
                        r_word <= w_lu_word;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_addr  <= '0;
                end
                default: begin
                    r_state <= IDLE;
                    r_step  <= '0;
                    r_addr  <= '0;
                    r_word  <= SAFE_WORD;
                end
            endcase
        end
    end

`ifdef DELTA_CTRL_PERF_EN
    logic [15:0] r_cyc_cnt;
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cyc_cnt   <= '0;
            r_stall_cnt <= '0;
        end else if (r_state == IDLE && i_start) begin
            r_cyc_cnt   <= '0;
            r_stall_cnt <= '0;
        end else if (r_state == RUN) begin
            if (r_cyc_cnt != 16'hFFFF) begin
                r_cyc_cnt <= r_cyc_cnt + 16'd1;
            end
            if (i_stall && r_stall_cnt != 16'hFFFF) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
        end
    end

    assign o_cyc_cnt   = r_cyc_cnt;
    assign o_stall_cnt = r_stall_cnt;
`endif

    assign o_busy         = (r_state == RUN);
    assign o_done         = (r_state == DONE);
    assign o_addr         = r_addr;
    assign o_sel_in1      = r_word.sel_in1;
    assign o_sel_in2      = r_word.sel_in2;
    assign o_sel_in3      = r_word.sel_in3;
    assign o_sel_in4      = r_word.sel_in4;
    assign o_sel_in5      = r_word.sel_in5;
    assign o_sel_x1_1     = r_word.sel_x1_1;
    assign o_sel_x1_2     = r_word.sel_x1_2;
    assign o_sel_x2_2     = r_word.sel_x2_2;
    assign o_sel_as_1     = r_word.sel_as_1;
    assign o_sel_as_2     = r_word.sel_as_2;
    assign o_sel_addsub   = r_word.sel_addsub;
    assign o_sel_temp     = r_word.sel_temp;
    assign o_dgate_valid  = r_word.dgate_valid;
    assign o_dgate_id     = r_word.dgate_id;
    assign o_dstate_valid = r_word.dstate_valid;

endmodule
